// File: rtl/bmp_fb_loader.sv
// bmp_fb_loader: parses a 24bpp BMP byte stream from the SD file reader and
// writes its pixels into the framebuffer in top-down raster order.
module bmp_fb_loader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sd_ready,
  input  logic                  file_found,
  input  logic                  outen,
  input  logic [7:0]            outbyte,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [23:0]           fb_wdata,
  output logic [3:0]            status,
  output logic                  done,
  output logic                  error
);

  // state   | meaning
  // IDLE    | waiting for the first byte of the file
  // HEADER  | capturing header bytes 0..53
  // SKIP    | discarding bytes up to the pixel-data offset
  // PIXEL   | assembling B,G,R bytes into pixels
  // PAD     | discarding row padding bytes
  // DONE    | every pixel written, terminal
  // ERROR   | header rejected, terminal
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SKIP, S_PIXEL, S_PAD, S_DONE, S_ERROR
  } state_t;

  localparam int CW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PAD = (4 - ((3 * H_ACTIVE) % 4)) % 4;

  localparam logic [CW-1:0]         COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [1:0]            PAD_LAST = 2'(PAD - 1);
  localparam logic [ADDR_WIDTH-1:0] BOT_ROW  = ADDR_WIDTH'((V_ACTIVE - 1) * H_ACTIVE);
  // Stepping from the end of one fb row to the start of the row above it.
  localparam logic [ADDR_WIDTH-1:0] ROW_BACK = ADDR_WIDTH'(2 * H_ACTIVE - 1);
  localparam logic [31:0]           H_W      = 32'(H_ACTIVE);
  localparam logic [31:0]           V_POS    = 32'(V_ACTIVE);
  localparam logic [31:0]           V_NEG    = 32'(-V_ACTIVE);

  state_t                state, state_nxt;
  logic   [3:0]          status_nxt;
  logic                  acc;
  logic                  hdr_ok;
  logic   [31:0]         bidx;
  logic   [15:0]         sig;
  logic   [31:0]         off;
  logic   [31:0]         width;
  logic   [31:0]         height;
  logic   [15:0]         bpp;
  logic   [31:0]         comp;
  logic   [1:0]          phase;
  logic   [7:0]          b_byte, g_byte;
  logic   [CW-1:0]       col;
  logic   [RW-1:0]       row;
  logic   [1:0]          pad_cnt;
  logic                  topdown;
  logic   [ADDR_WIDTH-1:0] pix_addr;

  assign acc = outen & file_found;

  // Signature is "BM" with 'B' as byte 0, so it reads 0x4D42 little-endian.
  assign hdr_ok = (sig == 16'h4D42) && (bpp == 16'd24) && (comp == 32'd0) &&
                  (width == H_W) && ((height == V_POS) || (height == V_NEG)) &&
                  (off >= 32'd54);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the status code that goes with the next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (acc) state_nxt = S_HEADER;
      S_HEADER: if (acc && bidx == 32'd53) begin
                  if (!hdr_ok)           state_nxt = S_ERROR;
                  else if (off > 32'd54) state_nxt = S_SKIP;
                  else                   state_nxt = S_PIXEL;
                end
      S_SKIP:   if (acc && bidx == off - 32'd1) state_nxt = S_PIXEL;
      S_PIXEL:  if (acc && phase == 2'd2 && col == COL_LAST) begin
                  if (row == ROW_LAST) state_nxt = S_DONE;
                  else if (PAD != 0)   state_nxt = S_PAD;
                end
      S_PAD:    if (acc && pad_cnt == PAD_LAST) state_nxt = S_PIXEL;
      default:  state_nxt = state;
    endcase

    status_nxt = 4'h0;
    case (state_nxt)
      S_ERROR:                 status_nxt = 4'hE;
      S_DONE:                  status_nxt = 4'h4;
      S_PIXEL, S_SKIP, S_PAD:  status_nxt = 4'h3;
      S_HEADER:                status_nxt = 4'h2;
      default: begin
        if (file_found)    status_nxt = 4'h2;
        else if (sd_ready) status_nxt = 4'h1;
      end
    endcase
  end

  // Byte counter and little-endian header field capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx   <= '0;
      sig    <= '0;
      off    <= '0;
      width  <= '0;
      height <= '0;
      bpp    <= '0;
      comp   <= '0;
    end else if (acc && state != S_DONE && state != S_ERROR) begin
      bidx <= bidx + 32'd1;
      if (state == S_IDLE || state == S_HEADER) begin
        if (bidx <= 32'd1)                      sig    <= {outbyte, sig[15:8]};
        if (bidx >= 32'd10 && bidx <= 32'd13)   off    <= {outbyte, off[31:8]};
        if (bidx >= 32'd18 && bidx <= 32'd21)   width  <= {outbyte, width[31:8]};
        if (bidx >= 32'd22 && bidx <= 32'd25)   height <= {outbyte, height[31:8]};
        if (bidx >= 32'd28 && bidx <= 32'd29)   bpp    <= {outbyte, bpp[15:8]};
        if (bidx >= 32'd30 && bidx <= 32'd33)   comp   <= {outbyte, comp[31:8]};
      end
    end
  end

  // Pixel assembly, incremental address walk and the framebuffer write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
      phase    <= '0;
      b_byte   <= '0;
      g_byte   <= '0;
      col      <= '0;
      row      <= '0;
      pad_cnt  <= '0;
      topdown  <= 1'b0;
      pix_addr <= '0;
    end else begin
      fb_we <= 1'b0;
      if (acc && state == S_HEADER && bidx == 32'd53) begin
        topdown  <= height[31];
        pix_addr <= height[31] ? '0 : BOT_ROW;
        col      <= '0;
        row      <= '0;
        phase    <= '0;
        pad_cnt  <= '0;
      end
      if (acc && state == S_PIXEL) begin
        case (phase)
          2'd0: begin b_byte <= outbyte; phase <= 2'd1; end
          2'd1: begin g_byte <= outbyte; phase <= 2'd2; end
          default: begin
            fb_we    <= 1'b1;
            fb_wdata <= {outbyte, g_byte, b_byte};
            fb_waddr <= pix_addr;
            phase    <= 2'd0;
            if (col == COL_LAST) begin
              col      <= '0;
              row      <= row + RW'(1);
              pix_addr <= topdown ? pix_addr + ADDR_WIDTH'(1) : pix_addr - ROW_BACK;
            end else begin
              col      <= col + CW'(1);
              pix_addr <= pix_addr + ADDR_WIDTH'(1);
            end
          end
        endcase
      end
      if (acc && state == S_PAD)
        pad_cnt <= (pad_cnt == PAD_LAST) ? 2'd0 : pad_cnt + 2'd1;
    end
  end

  // Registered status code and sticky completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= 4'h0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      status <= status_nxt;
      done   <= (state_nxt == S_DONE);
      error  <= (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_bmp_fb_loader.sv
// Testbench for bmp_fb_loader on a small 10x6 image (30 bytes per row, 2 pad bytes).
module tb_bmp_fb_loader;
  localparam int H  = 10;
  localparam int V  = 6;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sd_ready = 1'b0;
  logic          file_found = 1'b0;
  logic          outen = 1'b0;
  logic [7:0]    outbyte = 8'h00;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [23:0]   fb_wdata;
  logic [3:0]    status;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_err    = 0;
  int n_writes = 0;

  logic [7:0]  file_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  bmp_fb_loader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .sd_ready(sd_ready), .file_found(file_found),
    .outen(outen), .outbyte(outbyte), .fb_we(fb_we), .fb_waddr(fb_waddr),
    .fb_wdata(fb_wdata), .status(status), .done(done), .error(error)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must be the next expected (address, pixel).
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      n_writes++;
      if (exp_addr.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        check("waddr", 32'(fb_waddr), exp_addr.pop_front());
        check("wdata", 32'(fb_wdata), exp_data.pop_front());
      end
    end
  end

  task automatic put32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) file_q.push_back(v[8*i +: 8]);
  endtask

  // Builds the byte image of a BMP file and, for valid headers, the expected writes.
  task automatic build_file(input logic [15:0] sig, input int bpp, input int width,
                            input int height, input int off, input bit good);
    int pad;
    int fbrow;
    logic [7:0] b, g, r;
    file_q.delete();
    exp_addr.delete();
    exp_data.delete();
    pad = (4 - ((3 * H) % 4)) % 4;
    file_q.push_back(sig[7:0]);
    file_q.push_back(sig[15:8]);
    put32(32'(off + V * (3 * H + pad)));
    put32(32'd0);
    put32(32'(off));
    put32(32'd40);
    put32(32'(width));
    put32(32'(height));
    file_q.push_back(8'd1);
    file_q.push_back(8'd0);
    file_q.push_back(8'(bpp));
    file_q.push_back(8'(bpp >> 8));
    put32(32'd0);
    while (file_q.size() < 54) file_q.push_back(8'h00);
    while (file_q.size() < off) file_q.push_back(8'hAA);
    for (int fr = 0; fr < V; fr++) begin
      for (int c = 0; c < H; c++) begin
        b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
        file_q.push_back(b);
        file_q.push_back(g);
        file_q.push_back(r);
        if (good) begin
          fbrow = (height > 0) ? (V - 1 - fr) : fr;
          exp_addr.push_back(32'(fbrow * H + c));
          exp_data.push_back({8'h00, r, g, b});
        end
      end
      for (int p = 0; p < pad; p++) file_q.push_back(8'($urandom));
    end
  endtask

  // Streams file_q[from..to-1]; gap_pct adds idle or file_found=0 cycles between bytes.
  task automatic send(input int from, input int to, input int gap_pct);
    for (int i = from; i < to && i < file_q.size(); i++) begin
      if ($urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          if ($urandom_range(1) == 0) begin
            outen = 1'b0; file_found = 1'b1;
          end else begin
            outen = 1'b1; file_found = 1'b0; outbyte = 8'($urandom);
          end
        end
      end
      @(posedge clk); #1;
      outen = 1'b1; file_found = 1'b1; outbyte = file_q[i];
    end
    @(posedge clk); #1;
    outen = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1; outen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_writes = 0;
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic end_check(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_status"}, 32'(status), 32'h4);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_nwrites"}, 32'(n_writes), 32'(H * V));
    check({tag, "_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    // Reset state and idle status codes.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_waddr", 32'(fb_waddr), 32'd0);
    check("rst_wdata", 32'(fb_wdata), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    sd_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("status_sd_ok", 32'(status), 32'd1);
    file_found = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("status_found", 32'(status), 32'd2);

    // Bottom-up image at offset 54.
    do_reset();
    build_file(16'h4D42, 24, H, V, 54, 1'b1);
    check("bu_first_addr", exp_addr[0], 32'((V - 1) * H));
    send(0, file_q.size(), 0);
    end_check("bottom_up");

    // Top-down image.
    do_reset();
    build_file(16'h4D42, 24, H, -V, 54, 1'b1);
    send(0, file_q.size(), 0);
    end_check("top_down");

    // Extra header bytes before the pixel data.
    do_reset();
    build_file(16'h4D42, 24, H, V, 138, 1'b1);
    send(0, 138, 0);
    check("off138_nowrite", 32'(n_writes), 32'd0);
    check("off138_status", 32'(status), 32'd3);
    send(138, file_q.size(), 0);
    end_check("off138");

    // Random offsets and orientation with stream gaps and ignored strobes.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      build_file(16'h4D42, 24, H, ($urandom_range(1) != 0) ? V : -V,
                 int'($urandom_range(54, 90)), 1'b1);
      send(0, file_q.size(), 35);
      end_check("gaps");
    end

    // Rejected headers: bpp, width, signature, offset below 54.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      case (t)
        0: build_file(16'h4D42, 32, H, V, 54, 1'b0);
        1: build_file(16'h4D42, 24, 320, V, 54, 1'b0);
        2: build_file(16'h5842, 24, H, V, 54, 1'b0);
        default: build_file(16'h4D42, 24, H, V, 40, 1'b0);
      endcase
      send(0, 54, 0);
      check("bad_error", 32'(error), 32'd1);
      check("bad_status", 32'(status), 32'hE);
      send(54, file_q.size(), 10);
      repeat (3) @(posedge clk); #1;
      check("bad_nwrites", 32'(n_writes), 32'd0);
      check("bad_error_sticky", 32'(error), 32'd1);
      check("bad_done", 32'(done), 32'd0);
    end

    // Truncated stream, then reset mid-load and a fresh full reload.
    do_reset();
    build_file(16'h4D42, 24, H, V, 54, 1'b1);
    send(0, 54 + 3 * 25 + 1, 0);
    repeat (10) @(posedge clk); #1;
    check("trunc_status", 32'(status), 32'd3);
    check("trunc_done", 32'(done), 32'd0);
    check("trunc_nwrites", 32'(n_writes), 32'd24);
    rst = 1'b1;
    #1;
    check("midrst_we", 32'(fb_we), 32'd0);
    check("midrst_waddr", 32'(fb_waddr), 32'd0);
    check("midrst_wdata", 32'(fb_wdata), 32'd0);
    check("midrst_status", 32'(status), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    do_reset();
    build_file(16'h4D42, 24, H, V, 54, 1'b1);
    send(0, file_q.size(), 20);
    end_check("reload");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
